// File: rtl/snake_feeder.sv
// snake_feeder: walks a ROW x COL feature map in serpentine order, reads each
// pixel from a 1-cycle-latency memory and streams it out zero-extended to
// PEA_NUM lanes over a valid/ready handshake.
//
// Scan order: the first two rows are interleaved column by column (row 0,
// then row 1, for each column). After that, each remaining row is swept in
// alternating direction. Even rows run right to left and odd rows run left
// to right.
//
// Buffering: data_out is a registered output stage. Behind it is a 2-entry
// FIFO. A read is issued only while (FIFO entries + outstanding reads) after
// the current edge is below 2. This means every returning word always has
// a slot, even if the consumer stalls forever. Data on the read bus is moved
// straight into the output stage when that stage is free and the FIFO is
// empty. Otherwise it is queued.
module snake_feeder #(
    parameter int ROW     = 128,
    parameter int COL     = 128,
    parameter int CH_IN   = 4,
    parameter int PEA_NUM = 32,
    parameter int ADDR_W  = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [CH_IN*8-1:0]     mem_rdata,
    output logic [PEA_NUM*8-1:0]   data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int RW = $clog2(ROW);
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int PW = CH_IN * 8;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAD  = 3'd1,
        S_BODY  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [RW-1:0]       r_row;        // next pixel to read
    logic [CW-1:0]       r_col;
    logic                r_rd_en;
    logic                r_rd_pend;    // read data is on mem_rdata this cycle
    logic [ADDR_W-1:0]   r_addr;
    logic [PW-1:0]       r_pix;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic [PW-1:0]       r_fifo [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_fifo_cnt;

    logic                w_pop;
    logic                w_out_load;
    logic                w_fifo_pop;
    logic                w_bypass;
    logic                w_fifo_push;
    logic [1:0]          w_fifo_cnt_nxt;
    logic                w_room;
    logic                w_drained;
    logic [ADDR_W-1:0]   w_addr;
    logic [RW-1:0]       w_nrow;
    logic [CW-1:0]       w_ncol;
    logic                w_last;
    logic                w_to_body;

    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_addr;
    assign data_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    // Zero-extension keeps the unused upper lanes at zero in every cycle.
    assign data_out   = (PEA_NUM * 8)'(r_pix);

    // Buffer bookkeeping, read throttling and drain detection.
    always_comb begin
        w_pop          = r_valid & data_ready;
        w_out_load     = ~r_valid | w_pop;
        w_fifo_pop     = w_out_load & (r_fifo_cnt != 2'd0);
        w_bypass       = w_out_load & (r_fifo_cnt == 2'd0) & r_rd_pend;
        w_fifo_push    = r_rd_pend & ~w_bypass;
        w_fifo_cnt_nxt = r_fifo_cnt + {1'b0, w_fifo_push} - {1'b0, w_fifo_pop};
        // r_rd_en becomes the outstanding read after this edge.
        w_room         = ({1'b0, w_fifo_cnt_nxt} + {2'b00, r_rd_en}) < 3'd2;
        w_drained      = ~r_rd_en & ~r_rd_pend & (r_fifo_cnt == 2'd0) & w_out_load;
        w_addr         = ADDR_W'(r_row) * ADDR_W'(COL) + ADDR_W'(r_col);
    end

    // Serpentine successor of the pixel currently being read.
    always_comb begin
        w_nrow    = r_row;
        w_ncol    = r_col;
        w_last    = 1'b0;
        w_to_body = 1'b0;
        if (r_state == S_HEAD) begin
            if (r_row == RW'(0)) begin
                w_nrow = RW'(1);
            end else if (r_col == COL_LAST) begin
                if (ROW > 2) begin
                    // The first body row is even, so it starts at the right edge.
                    w_to_body = 1'b1;
                    w_nrow    = RW'(2);
                    w_ncol    = COL_LAST;
                end else begin
                    w_last = 1'b1;
                end
            end else begin
                w_nrow = RW'(0);
                w_ncol = r_col + CW'(1);
            end
        end else if (r_state == S_BODY) begin
            if (r_row[0] == 1'b0) begin
                if (r_col == CW'(0)) begin
                    // At the turn the column stays put and the row advances.
                    if (r_row == ROW_LAST) begin
                        w_last = 1'b1;
                    end else begin
                        w_nrow = r_row + RW'(1);
                    end
                end else begin
                    w_ncol = r_col - CW'(1);
                end
            end else begin
                if (r_col == COL_LAST) begin
                    if (r_row == ROW_LAST) begin
                        w_last = 1'b1;
                    end else begin
                        w_nrow = r_row + RW'(1);
                    end
                end else begin
                    w_ncol = r_col + CW'(1);
                end
            end
        end else begin
            w_last = 1'b0;
        end
    end

    // Frame control FSM: owns the scan position, read strobe/address, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_row   <= {RW{1'b0}};
            r_col   <= {CW{1'b0}};
            r_rd_en <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Pixel (0,0) is read immediately; (1,0) is next.
                        r_state <= S_HEAD;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_addr  <= {ADDR_W{1'b0}};
                        r_row   <= RW'(1);
                        r_col   <= {CW{1'b0}};
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                end
                S_HEAD, S_BODY: begin
                    if (w_room) begin
                        r_rd_en <= 1'b1;
                        r_addr  <= w_addr;
                        r_row   <= w_nrow;
                        r_col   <= w_ncol;
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (w_to_body) begin
                            r_state <= S_BODY;
                        end else begin
                            r_state <= r_state;
                        end
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    r_rd_en <= 1'b0;
                    if (w_drained) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    // Start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Read-data capture: output stage plus 2-entry FIFO behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_valid    <= 1'b0;
            r_pix      <= {PW{1'b0}};
            r_fifo_cnt <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo[0]  <= {PW{1'b0}};
            r_fifo[1]  <= {PW{1'b0}};
        end else begin
            r_rd_pend  <= r_rd_en;
            r_fifo_cnt <= w_fifo_cnt_nxt;
            if (w_out_load) begin
                if (w_fifo_pop) begin
                    r_pix    <= r_fifo[r_rd_ptr];
                    r_valid  <= 1'b1;
                    r_rd_ptr <= ~r_rd_ptr;
                end else if (w_bypass) begin
                    r_pix   <= mem_rdata;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end
            if (w_fifo_push) begin
                r_fifo[r_wr_ptr] <= mem_rdata;
                r_wr_ptr         <= ~r_wr_ptr;
            end
        end
    end

endmodule

// File: doc/snake_feeder.md
SNAKE_FEEDER -- requirements
Module: snake_feeder

Interface
- REQ-001 Parameter ROW, default 128, feature-map rows; legal range is 2 or more.
- REQ-002 Parameter COL, default 128, feature-map columns; legal range is 1 or more.
- REQ-003 Parameter CH_IN, default 4, input channels per pixel; each channel is 8 bits.
- REQ-004 Parameter PEA_NUM, default 32, output lanes; each lane is 8 bits; PEA_NUM shall be at least CH_IN.
- REQ-005 Parameter ADDR_W, default 14, memory address width; 2^ADDR_W shall be at least ROW*COL.
- REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
- REQ-007 rst  in  1  reset, synchronous, active-high.
- REQ-008 start  in  1  single-cycle request to begin one frame.
- REQ-009 mem_rd_en  out  1  read strobe to the pixel memory.
- REQ-010 mem_addr  out  ADDR_W  raster address, row*COL+col.
- REQ-011 mem_rdata  in  CH_IN*8  pixel word, valid exactly 1 cycle after its mem_rd_en.
- REQ-012 data_out  out  PEA_NUM*8  value {(PEA_NUM-CH_IN) zero bytes, pixel word}.
- REQ-013 data_valid  out  1  data_out holds a beat.
- REQ-014 data_ready  in  1  consumer accepts the beat; a beat transfers when data_valid and data_ready are both 1.
- REQ-015 busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- REQ-016 done  out  1  one-cycle pulse after the final beat transfers.

Function
- REQ-017 The scan order shall be the chip's serpentine order, as follows.
  - Head phase: for col = 0..COL-1, emit (row 0, col) and then (row 1, col).
  - Body phase: for row = 2..ROW-1, an even row runs col COL-1 down to 0 and an odd row runs col 0 up to COL-1.
- REQ-018 Exactly ROW*COL beats per frame, each pixel once, in the REQ-017 order; no gaps in the order and no duplicates.
- REQ-019 States shall be IDLE, HEAD, BODY, DRAIN and DONE, with these transitions:
  - IDLE to HEAD on start.
  - HEAD to BODY after the read of (1, COL-1) when ROW is greater than 2; HEAD to DRAIN after that read when ROW equals 2.
  - BODY to DRAIN after the last read is issued.
  - DRAIN to DONE when all beats have transferred.
  - DONE to IDLE after 1 cycle.
- REQ-020 Output buffering shall be a 2-entry FIFO.
  - mem_rd_en is asserted only when the sum of occupancy and reads in flight is less than 2.
  - The FIFO shall never overflow, and no read data shall be dropped.
- REQ-021 With data_ready held at 1 and no stalls, the first data_valid shall occur 2 cycles after start is sampled.
  - Beats then follow back-to-back at 1 per cycle.
  - done pulses 1 cycle after the final transfer.
- REQ-022 While data_valid is 1 and data_ready is 0, data_out shall hold stable, and data_valid shall not drop.
- REQ-023 start is ignored while busy is 1 or done is 1; a start sampled in the same cycle as done has no effect.
- REQ-024 Counters shall wrap/turn at the row ends with no dead cycle.
  - In the body phase, col direction flips on every row change.
  - The address shall be computed as row*COL+col with no truncation.
- REQ-025 The unused upper lanes of data_out shall always be zero, including while data_valid is 0.

Reset
- REQ-026 When rst is 1 at a rising edge:
  - state goes to IDLE and the FIFO empties.
  - In-flight reads are discarded; data arriving 1 cycle later is not captured.
  - mem_rd_en, data_valid, busy and done go to 0; mem_addr and data_out go to 0.
- REQ-027 rst asserted mid-frame aborts the frame, and no done is produced for it.
- REQ-028 A start sampled in the first cycle after rst deasserts shall be accepted.

Verification
- REQ-029 ROW=4, COL=3, mem[a]=a, data_ready=1 -> mem_addr/data beats shall be 0,3,1,4,2,5,8,7,6,9,10,11.
  - That is 12 beats, with upper lanes zero.
  - done pulses 1 cycle after beat 11.
- REQ-030 ROW=2, COL=4 -> beats 0,4,1,5,2,6,3,7, then done; BODY is never entered.
- REQ-031 ROW=4, COL=3, data_ready toggling 1,0,0,1,... -> beat order is the same as REQ-029.
  - data_out is stable during every stall.
  - mem_rd_en never issues while the FIFO plus in-flight count is 2.
- REQ-032 rst pulsed after beat 5 of the REQ-029 frame -> all outputs are 0 the next cycle and no done follows.
  - A new start then yields beat 0 first.
- REQ-033 start re-pulsed at beat 3 and in the done cycle -> both are ignored; exactly 1 frame of 12 beats and 1 done.
- REQ-034 ROW=128, COL=128, CH_IN=4, PEA_NUM=32, random mem contents -> 16384 beats in REQ-017 order.
  - Each beat is checked against a raster-to-serpentine reference model.
